// File: rtl/hw_to_sw_sender_pkg.sv
// Shared handshake constants and sender state type for the CPU PIO message path.
// The RECOVER state exists only when HW_SW_SEND_TIMEOUT_EN is defined.
package hw_sw_comm_pkg;

    localparam logic [1:0] SIG_IDLE = 2'd0;
    localparam logic [1:0] SIG_ACK  = 2'd1;
    localparam logic [1:0] SIG_MSG  = 2'd2;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_SEND,
        ST_ACK_WAIT
`ifdef HW_SW_SEND_TIMEOUT_EN
        ,
        ST_RECOVER
`endif
    } send_state_e;

    function automatic logic [1:0] sig_of_state(send_state_e s);
        logic [1:0] sig;
        sig = SIG_IDLE;
        case (s)
            ST_SEND:     sig = SIG_MSG;
            ST_ACK_WAIT: sig = SIG_ACK;
            default:     sig = SIG_IDLE;
        endcase
        return sig;
    endfunction

endpackage

// File: rtl/hw_to_sw_sender_if.sv
// Producer/CPU-side bundle of the hardware-to-software sender.
// timeout_pulse is present only when HW_SW_SEND_TIMEOUT_EN is defined.
interface hw_to_sw_sender_if #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              send_valid;
    logic [DATA_W-1:0] send_data;
    logic              send_ready;
    logic [1:0]        to_hw_sig;
    logic [1:0]        to_sw_sig;
    logic [DATA_W-1:0] to_sw_data;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
`ifdef HW_SW_SEND_TIMEOUT_EN
    logic              timeout_pulse;
`endif

    modport master (
        output send_valid,
        output send_data,
        output to_hw_sig,
        input  send_ready,
        input  to_sw_sig,
        input  to_sw_data,
        input  fifo_count,
`ifdef HW_SW_SEND_TIMEOUT_EN
        input  timeout_pulse,
`endif
        input  busy
    );

    modport slave (
        input  send_valid,
        input  send_data,
        input  to_hw_sig,
        output send_ready,
        output to_sw_sig,
        output to_sw_data,
        output fifo_count,
`ifdef HW_SW_SEND_TIMEOUT_EN
        output timeout_pulse,
`endif
        output busy
    );

endinterface

// File: rtl/hw_to_sw_sender_fifo.sv
// Small synchronous FIFO holding words waiting to be handed to software.
module hw_sw_send_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CW-1:0]     count_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok;
    logic              pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (count_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: a flush only moves the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/hw_to_sw_sender.sv
// Hardware-to-software message sender: FIFO plus to_sw_sig/to_hw_sig handshake.
// Optional handshake watchdog enabled by defining HW_SW_SEND_TIMEOUT_EN.
module hw_to_sw_sender
    import hw_sw_comm_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic               clk,
    input logic               reset,
    hw_to_sw_sender_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("hw_to_sw_sender: bad FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    send_state_e       state_q, state_d;
    logic [1:0]        sig_q;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              pop;
    logic              load;
    logic              busy;

    hw_sw_send_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (bus.send_valid),
        .data_i  (bus.send_data),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count),
        .full_o  (full)
    );

    assign busy = (state_q == ST_SEND) || (state_q == ST_ACK_WAIT);

`ifdef HW_SW_SEND_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TO_W-1:0] tmo_cnt_q;
    logic            tmo_hit;
    logic            tmo_pulse_q;

    assign tmo_hit = busy && (tmo_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_pulse_q <= tmo_hit;
            if (load)
                tmo_cnt_q <= '0;
            else if (busy)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign bus.timeout_pulse = tmo_pulse_q;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            ST_RESET: state_d = ST_IDLE;
            ST_IDLE: begin
                if (count != '0 && bus.to_hw_sig == SIG_IDLE) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                    data_d  = head;
                end
            end
            ST_SEND: begin
                if (bus.to_hw_sig == SIG_ACK) state_d = ST_ACK_WAIT;
            end
            ST_ACK_WAIT: begin
                if (bus.to_hw_sig == SIG_IDLE) begin
                    state_d = ST_IDLE;
                    pop     = 1'b1;
                end
            end
`ifdef HW_SW_SEND_TIMEOUT_EN
            ST_RECOVER: begin
                if (bus.to_hw_sig == SIG_IDLE) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_RESET;
        endcase
`ifdef HW_SW_SEND_TIMEOUT_EN
        // Watchdog wins over any handshake progress on the same edge.
        if (tmo_hit) begin
            state_d = ST_RECOVER;
            pop     = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            sig_q   <= SIG_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_of_state(state_d);
            data_q  <= data_d;
        end
    end

    assign bus.send_ready = !full;
    assign bus.to_sw_sig  = sig_q;
    assign bus.to_sw_data = data_q;
    assign bus.fifo_count = count;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_hw_to_sw_sender.sv
// Directed bench for hw_to_sw_sender: vector table plus reset/timeout sequences.
// The timeout sequence runs only when HW_SW_SEND_TIMEOUT_EN is defined.
module tb_hw_to_sw_sender;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hw_to_sw_sender_if #(.DATA_W(8), .FIFO_DEPTH(4)) bus ();

    hw_to_sw_sender #(
        .DATA_W         (8),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] hw;
        logic [1:0] sig;
        logic [7:0] data;
        logic [2:0] cnt;
        logic       rdy;
        logic       bsy;
    } vec_t;

    localparam int NV = 38;
    vec_t tbl [NV];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] hw,
                                logic [1:0] sig, logic [7:0] data,
                                logic [2:0] cnt, logic rdy, logic bsy);
        vec_t r;
        r.v = v; r.d = d; r.hw = hw;
        r.sig = sig; r.data = data; r.cnt = cnt; r.rdy = rdy; r.bsy = bsy;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [7:0] d, logic [1:0] hw);
        bus.send_valid = v;
        bus.send_data  = d;
        bus.to_hw_sig  = hw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] outs();
        return {bus.to_sw_sig, bus.to_sw_data, bus.fifo_count,
                bus.send_ready, bus.busy};
    endfunction

    initial begin
        // v   d      hw  | sig  data  cnt rdy bsy
        tbl[0]  = mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 0);
        tbl[1]  = mk(1, 8'hA5, 0, 0, 8'h00, 1, 1, 0);
        tbl[2]  = mk(0, 8'h00, 0, 2, 8'hA5, 1, 1, 1);
        tbl[3]  = mk(0, 8'h00, 1, 1, 8'hA5, 1, 1, 1);
        tbl[4]  = mk(0, 8'h00, 1, 1, 8'hA5, 1, 1, 1);
        tbl[5]  = mk(0, 8'h00, 0, 0, 8'hA5, 0, 1, 0);
        tbl[6]  = mk(1, 8'h01, 0, 0, 8'hA5, 1, 1, 0);
        tbl[7]  = mk(1, 8'h02, 0, 2, 8'h01, 2, 1, 1);
        tbl[8]  = mk(1, 8'h03, 0, 2, 8'h01, 3, 1, 1);
        tbl[9]  = mk(1, 8'h04, 0, 2, 8'h01, 4, 0, 1);
        tbl[10] = mk(1, 8'h05, 0, 2, 8'h01, 4, 0, 1);
        tbl[11] = mk(0, 8'h00, 1, 1, 8'h01, 4, 0, 1);
        tbl[12] = mk(1, 8'h99, 0, 0, 8'h01, 3, 1, 0);
        tbl[13] = mk(0, 8'h00, 0, 2, 8'h02, 3, 1, 1);
        tbl[14] = mk(0, 8'h00, 1, 1, 8'h02, 3, 1, 1);
        tbl[15] = mk(0, 8'h00, 0, 0, 8'h02, 2, 1, 0);
        tbl[16] = mk(0, 8'h00, 0, 2, 8'h03, 2, 1, 1);
        tbl[17] = mk(0, 8'h00, 1, 1, 8'h03, 2, 1, 1);
        tbl[18] = mk(0, 8'h00, 0, 0, 8'h03, 1, 1, 0);
        tbl[19] = mk(0, 8'h00, 0, 2, 8'h04, 1, 1, 1);
        tbl[20] = mk(0, 8'h00, 1, 1, 8'h04, 1, 1, 1);
        tbl[21] = mk(0, 8'h00, 0, 0, 8'h04, 0, 1, 0);
        tbl[22] = mk(0, 8'h00, 0, 0, 8'h04, 0, 1, 0);
        tbl[23] = mk(1, 8'h11, 0, 0, 8'h04, 1, 1, 0);
        tbl[24] = mk(0, 8'h00, 0, 2, 8'h11, 1, 1, 1);
        tbl[25] = mk(0, 8'h00, 1, 1, 8'h11, 1, 1, 1);
        tbl[26] = mk(1, 8'h22, 0, 0, 8'h11, 1, 1, 0);
        tbl[27] = mk(0, 8'h00, 0, 2, 8'h22, 1, 1, 1);
        tbl[28] = mk(0, 8'h00, 1, 1, 8'h22, 1, 1, 1);
        tbl[29] = mk(0, 8'h00, 0, 0, 8'h22, 0, 1, 0);
        tbl[30] = mk(1, 8'h33, 1, 0, 8'h22, 1, 1, 0);
        tbl[31] = mk(0, 8'h00, 1, 0, 8'h22, 1, 1, 0);
        tbl[32] = mk(0, 8'h00, 3, 0, 8'h22, 1, 1, 0);
        tbl[33] = mk(0, 8'h00, 0, 2, 8'h33, 1, 1, 1);
        tbl[34] = mk(0, 8'h00, 2, 2, 8'h33, 1, 1, 1);
        tbl[35] = mk(0, 8'h00, 1, 1, 8'h33, 1, 1, 1);
        tbl[36] = mk(0, 8'h00, 3, 1, 8'h33, 1, 1, 1);
        tbl[37] = mk(0, 8'h00, 0, 0, 8'h33, 0, 1, 0);

        reset = 1'b1;
        drive(0, 8'h00, 0);
        step();
        step();
        reset = 1'b0;
        check("rst_sig",   32'(bus.to_sw_sig),  32'd0);
        check("rst_data",  32'(bus.to_sw_data), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_ready", 32'(bus.send_ready), 32'd1);
        check("rst_busy",  32'(bus.busy),       32'd0);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].hw);
            step();
            check($sformatf("vec%0d", i), 32'(outs()),
                  32'({tbl[i].sig, tbl[i].data, tbl[i].cnt,
                       tbl[i].rdy, tbl[i].bsy}));
        end

        // Reset while in ACK_WAIT with three more words queued behind it.
        drive(1, 8'h44, 0); step();
        drive(1, 8'h55, 0); step();
        drive(1, 8'h66, 0); step();
        drive(1, 8'h77, 0); step();
        drive(0, 8'h00, 1); step();
        check("t5_ackwait", 32'({bus.to_sw_sig, bus.to_sw_data, bus.fifo_count}),
              32'({2'd1, 8'h44, 3'd4}));
        reset = 1'b1;
        drive(0, 8'h00, 0);
        step();
        reset = 1'b0;
        check("t5_flush", 32'(outs()),
              32'({2'd0, 8'h00, 3'd0, 1'b1, 1'b0}));
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t5_quiet%0d", i),
                  32'({bus.to_sw_sig, bus.fifo_count, bus.busy}), 32'd0);
        end

`ifdef HW_SW_SEND_TIMEOUT_EN
        begin
            int first;
            int pulses;
            first  = -1;
            pulses = 0;
            drive(1, 8'h3C, 0); step();
            drive(0, 8'h00, 0); step();
            check("t6_send", 32'({bus.to_sw_sig, bus.to_sw_data}),
                  32'({2'd2, 8'h3C}));
            for (int i = 1; i <= 40; i++) begin
                step();
                if (bus.timeout_pulse) begin
                    first = i;
                    break;
                end
            end
            check("t6_when", 32'(first), 32'd16);
            check("t6_drop", 32'({bus.to_sw_sig, bus.fifo_count, bus.busy}),
                  32'd0);
            step();
            if (bus.timeout_pulse) pulses++;
            check("t6_pulse1", 32'(pulses), 32'd0);
            drive(1, 8'h5A, 0); step();
            drive(0, 8'h00, 0); step();
            check("t6_relaunch", 32'({bus.to_sw_sig, bus.to_sw_data,
                                      bus.timeout_pulse}),
                  32'({2'd2, 8'h5A, 1'b0}));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hw_to_sw_sender.md
Name: hw_to_sw_sender

Overview:
Hardware-to-software message transmitter; the reverse direction of the existing 2-bit software-to-hardware handshake. Hardware producers push data words into a small FIFO. The block presents each word to the CPU on a PIO data port and handshakes it out over a dedicated to_sw_sig/to_hw_sig pair. Sits beside hardware_software_comm at the CPU PIO boundary.

Parameters:
DATA_W, 8, width of one message word
FIFO_DEPTH, 4, FIFO entries; power of 2, ≥2
TIMEOUT_CYCLES, 1024, handshake watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
send_valid  in  1  producer push request
send_data  in  DATA_W  producer word
send_ready  out  1  FIFO not full; push accepted when send_valid & send_ready
to_hw_sig  in  2  software handshake: 0=idle, 1=ack (word read), 2/3=ignored
to_sw_sig  out  2  hardware handshake: 0=idle, 2=message valid, 1=ack seen
to_sw_data  out  DATA_W  current message word, registered
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
busy  out  1  state is SEND or ACK_WAIT

Behaviour:
- Reset (sync, on clk edge with reset=1):
  - state=RESET, FIFO flushed, fifo_count=0, to_sw_sig=0, to_sw_data=0.
  - send_ready=1 from the first cycle after reset.
  - Reset mid-handshake: the in-flight word and all queued words are lost.
- States: RESET, IDLE, SEND, ACK_WAIT (plus RECOVER with the optional feature). to_sw_sig is a registered decode of the state: RESET/IDLE/RECOVER→0, SEND→2, ACK_WAIT→1.
- RESET→IDLE unconditionally after one cycle.
- IDLE→SEND when fifo_count≠0 and to_hw_sig==0. On this edge to_sw_data loads the FIFO head. The head is not popped yet.
- IDLE holds while to_hw_sig≠0, because software has not finished the previous handshake.
- SEND→ACK_WAIT when to_hw_sig==1. to_sw_data stays stable throughout SEND and ACK_WAIT.
- ACK_WAIT→IDLE when to_hw_sig==0. The FIFO pops on this edge.
- to_hw_sig values 2 and 3 are treated as "no change" in every state.
- Latency: a push accepted at edge N into an empty FIFO, with the block in IDLE and to_hw_sig==0, gives to_sw_sig==2 and valid data after edge N+1. Minimum per-message cost is 3 cycles plus software response time.
- Back-to-back messages: after ACK_WAIT→IDLE, the next word launches on the following edge if fifo_count≠0 and to_hw_sig==0.
- FIFO rules:
  - Push when full: ignored, because send_ready=0.
  - Simultaneous push and pop: both occur, fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
  - Push into a full FIFO on the same edge as a pop is not accepted, because send_ready is computed from the current count.

Optional Feature:
- Macro: HW_SW_SEND_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to SEND and increments each cycle in SEND or ACK_WAIT.
  - Reaching TIMEOUT_CYCLES-1 pops the in-flight word, pulses output port timeout_pulse for 1 cycle, and enters RECOVER with to_sw_sig=0.
  - RECOVER→IDLE when to_hw_sig==0.
  - timeout_pulse (out, 1 bit, reset 0) exists only when the macro is defined.
- Without the macro: no counter, no RECOVER state, no timeout_pulse port; the block waits on software indefinitely.

Decomposition:
- Package hw_sw_comm_pkg holds:
  - handshake constants SIG_IDLE=2'd0, SIG_ACK=2'd1, SIG_MSG=2'd2, shared with hardware_software_comm;
  - the sender state enum typedef.
- Sub-module hw_sw_send_fifo: parameterised synchronous FIFO providing push, pop, head, count and full.

Test Plan:
1. Reset for 2 cycles, then release → to_sw_sig=0, to_sw_data=0, fifo_count=0, send_ready=1, busy=0.
2. Push 0xA5 with to_hw_sig=0 → 2 cycles later to_sw_sig=2, to_sw_data=0xA5. Drive to_hw_sig=1 → to_sw_sig=1. Drive to_hw_sig=0 → to_sw_sig=0, fifo_count=0.
3. Hold to_hw_sig=0 and push 0x01..0x05 into a 4-deep FIFO → 0x05 rejected (send_ready=0 at count 4). Handshake 4 times → software reads 0x01,0x02,0x03,0x04 in order.
4. Push while to_hw_sig=1 is held from the previous message → block stays IDLE, to_sw_sig=0 until to_hw_sig returns to 0, then launches.
5. Assert reset while in ACK_WAIT with 3 words queued → next cycle to_sw_sig=0, fifo_count=0; no queued word is ever presented.
6. With HW_SW_SEND_TIMEOUT_EN and TIMEOUT_CYCLES=16, push 0x3C and never ack → timeout_pulse=1 for 1 cycle; the word is dropped; the block returns to IDLE once to_hw_sig==0.
